// File: rtl/if_tile_controller_if.sv
// Control/stream bundle between the CNN controller (master) and the IF read sequencer (slave).
interface if_tile_controller_if #(
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned TILE_W = 8,
    parameter int unsigned CH_W   = 2
);
    logic              start_if;
    logic              abort;
    logic [TILE_W-1:0] num_tiles;
    logic [ADDR_W-1:0] base_addr;
    logic              cons_ready;
    logic              if_ready;
    logic              clr_if;
    logic              if_read;
    logic [ADDR_W-1:0] if_addr;
    logic [CH_W-1:0]   if_ch;
    logic              if_valid;
    logic              if_last;
    logic [TILE_W-1:0] tile_idx;
    logic              if_done;

    modport master (
        output start_if, abort, num_tiles, base_addr, cons_ready,
        input  if_ready, clr_if, if_read, if_addr, if_ch, if_valid, if_last, tile_idx, if_done
    );

    modport slave (
        input  start_if, abort, num_tiles, base_addr, cons_ready,
        output if_ready, clr_if, if_read, if_addr, if_ch, if_valid, if_last, tile_idx, if_done
    );
endinterface

// File: rtl/if_tile_controller.sv
// IF buffer read sequencer: per tile, one clear pulse, then NUM_CH x ROWS x COLS reads
// gated by consumer backpressure, then a drain of the SRAM read pipe.
module if_tile_controller #(
    parameter int unsigned NUM_CH   = 4,
    parameter int unsigned ROWS     = 8,
    parameter int unsigned COLS     = 8,
    parameter int unsigned ADDR_W   = 12,
    parameter int unsigned TILE_W   = 8,
    parameter int unsigned READ_LAT = 1
) (
    input logic                clk,
    input logic                rst,
    if_tile_controller_if.slave bus
);
    localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int unsigned COL_W = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int unsigned LAT_W = $clog2(READ_LAT + 1);
    localparam int unsigned TILE_LEN = NUM_CH * ROWS * COLS;
    localparam logic [ADDR_W-1:0] TILE_STEP = ADDR_W'(TILE_LEN);

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StClear = 3'd1;
    localparam logic [2:0] StRead  = 3'd2;
    localparam logic [2:0] StDrain = 3'd3;
    localparam logic [2:0] StDone  = 3'd4;

    logic [2:0]          state_q, state_d;
    logic [TILE_W-1:0]   ntiles_q, tile_q;
    logic [ADDR_W-1:0]   base_q, offs_q;
    logic [CH_W-1:0]     ch_q;
    logic [ROW_W-1:0]    row_q;
    logic [COL_W-1:0]    col_q;
    logic [LAT_W-1:0]    drain_q;
    logic [READ_LAT-1:0] vpipe_q, lpipe_q;
    logic                rd, rd_last, col_end, row_end, ch_end, drain_end, last_tile;

    assign col_end   = (col_q == COL_W'(COLS - 1));
    assign row_end   = (row_q == ROW_W'(ROWS - 1));
    assign ch_end    = (ch_q == CH_W'(NUM_CH - 1));
    assign rd        = (state_q == StRead) && bus.cons_ready;
    assign rd_last   = rd && ch_end && row_end && col_end;
    assign drain_end = (drain_q == LAT_W'(READ_LAT - 1));
    assign last_tile = (tile_q == ntiles_q - TILE_W'(1));

    // Next-state logic; abort overrides every transition.
    always_comb begin
        state_d = state_q;
        if (bus.abort) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle:  if (bus.start_if) state_d = (bus.num_tiles == '0) ? StDone : StClear;
                StClear: state_d = StRead;
                StRead:  if (rd_last) state_d = StDrain;
                StDrain: if (drain_end) state_d = last_tile ? StDone : StClear;
                StDone:  state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    // State, job parameters and beat counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StIdle;
            ntiles_q <= '0;
            tile_q   <= '0;
            base_q   <= '0;
            offs_q   <= '0;
            ch_q     <= '0;
            row_q    <= '0;
            col_q    <= '0;
            drain_q  <= '0;
        end else begin
            state_q <= state_d;
            drain_q <= (state_q == StDrain) ? drain_q + LAT_W'(1) : '0;
            if (state_q == StIdle && bus.start_if && !bus.abort) begin
                ntiles_q <= bus.num_tiles;
                base_q   <= bus.base_addr;
                tile_q   <= '0;
            end
            if (state_q == StClear) begin
                offs_q <= '0;
                ch_q   <= '0;
                row_q  <= '0;
                col_q  <= '0;
            end
            if (rd) begin
                offs_q <= offs_q + ADDR_W'(1);
                if (col_end) begin
                    col_q <= '0;
                    if (row_end) begin
                        row_q <= '0;
                        ch_q  <= ch_end ? '0 : ch_q + CH_W'(1);
                    end else begin
                        row_q <= row_q + ROW_W'(1);
                    end
                end else begin
                    col_q <= col_q + COL_W'(1);
                end
            end
            if (state_q == StDrain && state_d == StClear) begin
                tile_q <= tile_q + TILE_W'(1);
                base_q <= base_q + TILE_STEP;
            end
        end
    end

    // SRAM latency model: delays read/last flags; abort drops anything in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vpipe_q <= '0;
            lpipe_q <= '0;
        end else if (bus.abort) begin
            vpipe_q <= '0;
            lpipe_q <= '0;
        end else begin
            vpipe_q <= READ_LAT'({vpipe_q, rd});
            lpipe_q <= READ_LAT'({lpipe_q, rd_last});
        end
    end

    assign bus.if_ready = (state_q == StIdle);
    assign bus.clr_if   = (state_q == StClear);
    assign bus.if_done  = (state_q == StDone);
    assign bus.if_read  = rd;
    assign bus.if_addr  = rd ? base_q + offs_q : '0;
    assign bus.if_ch    = rd ? ch_q : '0;
    assign bus.if_valid = vpipe_q[READ_LAT-1];
    assign bus.if_last  = lpipe_q[READ_LAT-1];
    assign bus.tile_idx = tile_q;
endmodule
